// File: rtl/uart_dbg_bridge.sv
// uart_dbg_bridge: UART byte-stream debug bridge to a classic Wishbone master.
// Frames: 'w' adr4 dat4 -> 'k'; 'r' adr4 -> dat4; 'g' adr4 -> 'k' then go pulse.
module uart_dbg_bridge #(
    parameter int timeout_cycles = 1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_avail,
    output logic        rx_ack,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i,
    output logic        go,
    output logic [31:0] go_adr
);
    localparam int TW = $clog2(timeout_cycles + 1);

    typedef enum logic [2:0] {IDLE, ADR, DAT, BUS, EXEC, TX} state_t;

    state_t        state;
    logic [7:0]    op;
    logic [1:0]    cnt;
    logic [1:0]    left;
    logic [TW-1:0] timer;
    logic [31:0]   rbuf;
    logic          guard;
    logic          gpend;
    logic          take;
    logic          tx_ok;
    logic          in_frame;

    assign in_frame = (state == ADR) || (state == DAT);
    assign take     = rx_avail && !rx_ack && (state == IDLE || in_frame);
    // guard keeps a one-cycle gap after each strobe so tx_busy has time to rise
    assign tx_ok    = !tx_busy && !tx_wr && !guard;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            op       <= '0;
            cnt      <= '0;
            left     <= '0;
            timer    <= '0;
            rbuf     <= '0;
            guard    <= 1'b0;
            gpend    <= 1'b0;
            rx_ack   <= 1'b0;
            tx_wr    <= 1'b0;
            tx_data  <= '0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_sel_o <= '0;
            wb_we_o  <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            go       <= 1'b0;
            go_adr   <= '0;
        end else begin
            rx_ack <= take;
            tx_wr  <= 1'b0;
            guard  <= tx_wr;
            go     <= tx_wr && gpend;
            timer  <= (take || !in_frame) ? '0 : timer + 1'b1;
            if (tx_wr)
                gpend <= 1'b0;
            case (state)
                IDLE: if (take) begin
                    op  <= rx_data;
                    cnt <= '0;
                    if (rx_data == 8'h77 || rx_data == 8'h72 || rx_data == 8'h67) begin
                        state <= ADR;
                    end else begin
                        rbuf  <= {8'h3F, 24'h0};
                        left  <= '0;
                        state <= TX;
                    end
                end
                ADR: if (take) begin
                    wb_adr_o <= {wb_adr_o[23:0], rx_data};
                    cnt      <= cnt + 1'b1;
                    if (cnt == 2'd3) begin
                        if (op == 8'h77) begin
                            state <= DAT;
                        end else if (op == 8'h72) begin
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_sel_o <= 4'hF;
                            wb_we_o  <= 1'b0;
                            state    <= BUS;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end else if (timer == TW'(timeout_cycles - 1)) begin
                    cnt   <= '0;
                    state <= IDLE;
                end
                DAT: if (take) begin
                    wb_dat_o <= {wb_dat_o[23:0], rx_data};
                    cnt      <= cnt + 1'b1;
                    if (cnt == 2'd3) begin
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_sel_o <= 4'hF;
                        wb_we_o  <= 1'b1;
                        state    <= BUS;
                    end
                end else if (timer == TW'(timeout_cycles - 1)) begin
                    cnt   <= '0;
                    state <= IDLE;
                end
                BUS: if (wb_ack_i) begin
                    wb_cyc_o <= 1'b0;
                    wb_stb_o <= 1'b0;
                    wb_sel_o <= '0;
                    wb_we_o  <= 1'b0;
                    rbuf     <= wb_we_o ? {8'h6B, 24'h0} : wb_dat_i;
                    left     <= wb_we_o ? 2'd0 : 2'd3;
                    state    <= TX;
                end
                EXEC: begin
                    go_adr <= wb_adr_o;
                    rbuf   <= {8'h6B, 24'h0};
                    left   <= '0;
                    gpend  <= 1'b1;
                    state  <= TX;
                end
                TX: if (tx_ok) begin
                    tx_data <= rbuf[31:24];
                    rbuf    <= {rbuf[23:0], 8'h0};
                    tx_wr   <= 1'b1;
                    left    <= left - 1'b1;
                    if (left == 2'd0)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_dbg_bridge.sv
// tb_uart_dbg_bridge: directed frames with scoreboard queues for Wishbone accesses,
// transmitted bytes and go pulses; monitors pop and compare as the DUT produces them.
module tb_uart_dbg_bridge;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_avail = 1'b0;
    logic        rx_ack;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy = 1'b0;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_ack_i = 1'b0;
    logic        go;
    logic [31:0] go_adr;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } wb_t;

    wb_t        wb_q[$];
    logic [7:0] tx_q[$];
    logic [31:0] go_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_dbg_bridge #(.timeout_cycles(100)) dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_avail(rx_avail), .rx_ack(rx_ack),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i), .go(go), .go_adr(go_adr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    task automatic push_wb(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        wb_t e;
        e.we  = we;
        e.adr = adr;
        e.dat = dat;
        wb_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_avail = 1'b1;
        for (int n = 0; n < 5000; n++) begin
            @(negedge clk);
            if (rx_ack) break;
        end
        chk("rx_ack_wait", rx_ack, 1);
        rx_avail = 1'b0;
    endtask

    task automatic send_frame(input logic [71:0] f, input int n);
        for (int i = 0; i < n; i++)
            send(f[71-8*i -: 8]);
    endtask

    task automatic drain();
        for (int n = 0; n < 3000 && (wb_q.size() + tx_q.size() + go_q.size()) != 0; n++)
            @(negedge clk);
        repeat (20) @(negedge clk);
    endtask

    // Wishbone slave: acks after three wait cycles and checks each access
    initial begin
        int w = 0;
        int cyc_n = 0;
        logic acked = 1'b0;
        wb_t e;
        forever begin
            @(negedge clk);
            if (wb_cyc_o) begin
                cyc_n++;
            end else if (cyc_n != 0) begin
                if (acked) chk("wb_cyc_len", cyc_n, 4);
                cyc_n = 0;
                acked = 1'b0;
            end
            if (wb_ack_i) begin
                wb_ack_i = 1'b0;
                wb_dat_i = '0;
            end else if (wb_cyc_o && wb_stb_o) begin
                if (w == 3) begin
                    w = 0;
                    acked = 1'b1;
                    wb_ack_i = 1'b1;
                    if (wb_q.size() == 0) begin
                        unexpected("wb_access", {31'h0, wb_we_o, wb_adr_o});
                    end else begin
                        e = wb_q.pop_front();
                        chk("wb_we", wb_we_o, e.we);
                        chk("wb_adr", wb_adr_o, e.adr);
                        chk("wb_sel", wb_sel_o, 4'hF);
                        if (e.we) chk("wb_dat", wb_dat_o, e.dat);
                        else wb_dat_i = e.dat;
                    end
                end else begin
                    w++;
                end
            end else begin
                w = 0;
            end
        end
    end

    // UART transmitter model and reply checker
    initial begin
        int bc = 0;
        logic prev_wr = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_wr) begin
                chk("tx_spacing", {tx_busy, prev_wr}, 2'b00);
                if (tx_q.size() == 0) unexpected("tx_byte", tx_data);
                else chk("tx_data", tx_data, tx_q.pop_front());
                tx_busy = 1'b1;
                bc = 6;
            end else if (bc > 0) begin
                bc--;
                if (bc == 0) tx_busy = 1'b0;
            end
            prev_wr = tx_wr;
        end
    end

    // go pulse and rx_ack pulse-width monitor
    initial begin
        logic prev_wr = 1'b0;
        logic prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (go) begin
                if (go_q.size() == 0) unexpected("go_pulse", go_adr);
                else chk("go_adr", go_adr, go_q.pop_front());
                chk("go_after_tx", prev_wr, 1);
            end
            if (rx_ack) chk("rx_ack_single", prev_ack, 0);
            prev_wr  = tx_wr;
            prev_ack = rx_ack;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {rx_ack, tx_wr, tx_data, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, go}, 0);
        chk("reset_adr", wb_adr_o, 0);
        chk("reset_dat", wb_dat_o, 0);
        chk("reset_go_adr", go_adr, 0);
        reset_n = 1'b1;

        push_wb(1'b1, 32'h00001000, 32'hDEADBEEF);
        tx_q.push_back(8'h6B);
        send_frame({8'h77, 32'h00001000, 32'hDEADBEEF}, 9);
        drain();

        push_wb(1'b0, 32'h00001000, 32'h12345678);
        tx_q.push_back(8'h12); tx_q.push_back(8'h34); tx_q.push_back(8'h56); tx_q.push_back(8'h78);
        send_frame({8'h72, 32'h00001000, 32'h0}, 5);
        drain();

        go_q.push_back(32'h00000000);
        tx_q.push_back(8'h6B);
        send_frame({8'h67, 32'h00000000, 32'h0}, 5);
        drain();

        go_q.push_back(32'h12345678);
        tx_q.push_back(8'h6B);
        send_frame({8'h67, 32'h12345678, 32'h0}, 5);
        drain();

        tx_q.push_back(8'h3F);
        send(8'h41);
        drain();
        push_wb(1'b0, 32'h00000080, 32'hA5A55A5A);
        tx_q.push_back(8'hA5); tx_q.push_back(8'hA5); tx_q.push_back(8'h5A); tx_q.push_back(8'h5A);
        send_frame({8'h72, 32'h00000080, 32'h0}, 5);
        drain();

        send_frame({8'h72, 16'h0000, 48'h0}, 3);
        repeat (150) @(negedge clk);
        push_wb(1'b0, 32'h00000004, 32'hCAFEF00D);
        tx_q.push_back(8'hCA); tx_q.push_back(8'hFE); tx_q.push_back(8'hF0); tx_q.push_back(8'h0D);
        send_frame({8'h72, 32'h00000004, 32'h0}, 5);
        drain();

        push_wb(1'b1, 32'hFFFFFFFC, 32'h00000001);
        tx_q.push_back(8'h6B);
        send_frame({8'h77, 32'hFFFFFFFC, 32'h00000001}, 9);
        drain();

        send_frame({8'h72, 32'h00002000, 32'h0}, 5);
        for (int n = 0; n < 50 && !wb_stb_o; n++) @(negedge clk);
        chk("stb_before_reset", wb_stb_o, 1);
        reset_n = 1'b0;
        #1;
        chk("reset_drops_cyc_stb", {wb_cyc_o, wb_stb_o}, 2'b00);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);

        push_wb(1'b0, 32'h00000008, 32'h0BADC0DE);
        tx_q.push_back(8'h0B); tx_q.push_back(8'hAD); tx_q.push_back(8'hC0); tx_q.push_back(8'hDE);
        send_frame({8'h72, 32'h00000008, 32'h0}, 5);
        drain();

        chk("wb_q_empty", wb_q.size(), 0);
        chk("tx_q_empty", tx_q.size(), 0);
        chk("go_q_empty", go_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
